// File: rtl/data_memory_interface_pkg.sv
// Shared encodings for the data-memory stage:
// access sizes, read/write polarity and FSM states.
package mem_if_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int CNT_W = 4;

    // Reserved size or an address not aligned to the access width.
    function automatic logic f_bad_access(
        input size_t      sz,
        input logic [1:0] lsb
    );
        return (sz == SZ_RSVD)
            || (sz == SZ_HALF && lsb[0])
            || (sz == SZ_WORD && lsb != 2'b00);
    endfunction

endpackage

// File: rtl/data_memory_interface_if.sv
// Request/response bundle between the CPU datapath
// and the data-memory stage.
interface data_memory_interface_if;

    logic        MOV;
    logic        RW;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AlignErr;
    logic        Busy;

    modport master (
        output MOV, RW, Size, SignExt, Address, DataIn,
        input  DataOut, MOC, AlignErr, Busy
    );

    modport slave (
        input  MOV, RW, Size, SignExt, Address, DataIn,
        output DataOut, MOC, AlignErr, Busy
    );

endinterface

// File: rtl/data_memory_interface_mem_load_formatter.sv
// Builds the 32-bit load result from four big-endian
// bytes, applying size, sign/zero extension and error.
module mem_load_formatter
    import mem_if_pkg::*;
(
    input  logic [3:0][7:0] i_bytes,
    input  size_t           i_size,
    input  logic            i_sign_ext,
    input  logic            i_err,
    output logic [31:0]     o_data
);

    logic w_byte;
    logic w_half;
    logic w_word;
    logic w_fill;

    assign w_byte = !i_err && (i_size == SZ_BYTE);
    assign w_half = !i_err && (i_size == SZ_HALF);
    assign w_word = !i_err && (i_size == SZ_WORD);

    // Byte 0 holds the MSB of every access width.
    assign w_fill = i_sign_ext & i_bytes[0][7];

    always_comb begin
        o_data = '0;
        unique case (1'b1)
            w_byte: o_data = {{24{w_fill}}, i_bytes[0]};
            w_half: o_data = {{16{w_fill}}, i_bytes[0], i_bytes[1]};
            w_word: o_data = {i_bytes[0], i_bytes[1],
                              i_bytes[2], i_bytes[3]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_interface.sv
// Data-memory stage: latches a request, waits LATENCY edges,
// performs a big-endian access and answers with MOC.
module data_memory_interface
    import mem_if_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 9,
    parameter int LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_interface_if.slave  bus
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rw;
    size_t              r_size;
    logic               r_sext;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_dout;
    logic               r_err;
    logic [7:0]         r_mem [DEPTH_BYTES];

    logic               w_capture;
    logic               w_access;
    logic               w_err;
    logic               w_we;
    logic [3:0][ADDR_W-1:0] w_a;
    logic [3:0][7:0]    w_rbytes;
    logic [31:0]        w_load;
    logic               w_unused_addr;

    assign w_unused_addr = ^bus.Address[31:ADDR_W];

    assign w_capture = (r_state == ST_IDLE) && bus.MOV;
    assign w_access  = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_err     = f_bad_access(r_size, r_addr[1:0]);
    assign w_we      = w_access && (r_rw == RW_WRITE) && !w_err;

    // Byte lanes wrap naturally in the ADDR_W-bit sum.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a[i]      = r_addr + ADDR_W'(i);
            w_rbytes[i] = r_mem[w_a[i]];
        end
    end

    mem_load_formatter u_fmt (
        .i_bytes    (w_rbytes),
        .i_size     (r_size),
        .i_sign_ext (r_sext),
        .i_err      (w_err),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.MOV)       w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == '0)   w_next = ST_DONE;
            ST_DONE: if (!bus.MOV)      w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.MOC      = (r_state == ST_DONE);
        bus.AlignErr = (r_state == ST_DONE) && r_err;
        bus.Busy     = (r_state != ST_IDLE);
        bus.DataOut  = r_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_rw    <= RW_WRITE;
            r_size  <= SZ_BYTE;
            r_sext  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cnt   <= CNT_W'(LATENCY - 1);
                r_rw    <= bus.RW;
                r_size  <= size_t'(bus.Size);
                r_sext  <= bus.SignExt;
                r_addr  <= bus.Address[ADDR_W-1:0];
                r_wdata <= bus.DataIn;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_err <= w_err;
                if (w_err || r_rw == RW_READ) begin
                    r_dout <= w_load;
                end
            end else if (r_state == ST_DONE && !bus.MOV) begin
                r_err <= 1'b0;
            end
        end
    end

    // Array is not reset; w_we is already gated off while in reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            case (r_size)
                SZ_BYTE: begin
                    r_mem[w_a[0]] <= r_wdata[7:0];
                end
                SZ_HALF: begin
                    r_mem[w_a[0]] <= r_wdata[15:8];
                    r_mem[w_a[1]] <= r_wdata[7:0];
                end
                SZ_WORD: begin
                    r_mem[w_a[0]] <= r_wdata[31:24];
                    r_mem[w_a[1]] <= r_wdata[23:16];
                    r_mem[w_a[2]] <= r_wdata[15:8];
                    r_mem[w_a[3]] <= r_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_interface.sv
// Scoreboard bench for data_memory_interface: byte-array
// reference model, directed plan items, then random traffic.
module tb_data_memory_interface;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        time         cap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_interface_if bus();

    data_memory_interface #(
        .DEPTH_BYTES (DEPTH),
        .ADDR_W      (AW),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        q[$];
    logic [7:0]  mdl [DEPTH];
    logic [31:0] last_dout = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_moc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: applies one request to the byte array.
    task automatic model(input logic rw, input logic [1:0] sz,
                         input logic sx, input logic [31:0] addr,
                         input logic [31:0] d, output exp_t e);
        int a;
        int n;
        logic [31:0] v;
        a = int'(addr % DEPTH);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
             || (sz == 2'd2 && a % 4 != 0);
        if (e.err) begin
            e.dout = '0;
        end else if (rw) begin
            v = '0;
            for (int i = 0; i < n; i++)
                v = (v << 8) | 32'(mdl[(a + i) % DEPTH]);
            if (sx && n < 4 && v[8*n-1])
                v = v | (32'hFFFF_FFFF << (8 * n));
            e.dout = v;
        end else begin
            for (int i = 0; i < n; i++)
                mdl[(a + i) % DEPTH] = d[8*(n-1-i) +: 8];
            e.dout = last_dout;
        end
        last_dout = e.dout;
    endtask

    task automatic scramble();
        bus.RW      = 1'($urandom);
        bus.Size    = 2'($urandom);
        bus.SignExt = 1'($urandom);
        bus.Address = $urandom;
        bus.DataIn  = $urandom;
    endtask

    task automatic hard_reset();
        bus.MOV = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        last_dout = '0;
    endtask

    task automatic req(input logic rw, input logic [1:0] sz,
                       input logic sx, input logic [31:0] addr,
                       input logic [31:0] d, input int hold,
                       input bit drop);
        exp_t e;
        bit seen;
        @(negedge clk);
        bus.MOV = 1'b1; bus.RW = rw; bus.Size = sz;
        bus.SignExt = sx; bus.Address = addr; bus.DataIn = d;
        @(posedge clk);
        model(rw, sz, sx, addr, d, e);
        e.cap = $time;
        q.push_back(e);
        @(negedge clk);
        chk("busy_wait", 32'(bus.Busy), 32'd1);
        scramble();
        if (drop) bus.MOV = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            if (bus.MOC) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL moc_timeout: got 0 want 1 within 40 cycles");
            hard_reset();
            return;
        end
        if (drop) begin
            @(negedge clk);
            chk("moc_pulse", 32'(bus.MOC), 32'd0);
            chk("busy_pulse", 32'(bus.Busy), 32'd0);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                chk("moc_held", 32'(bus.MOC), 32'd1);
                scramble();
            end
            bus.MOV = 1'b0;
            @(negedge clk);
            chk("moc_drop", 32'(bus.MOC), 32'd0);
            chk("busy_drop", 32'(bus.Busy), 32'd0);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.MOC && !prev_moc) begin
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_moc: got 1 want 0");
            end else begin
                e = q.pop_front();
                chk("dataout", bus.DataOut, e.dout);
                chk("alignerr", 32'(bus.AlignErr), 32'(e.err));
                chk("latency", 32'(($time - e.cap - 5) / 10), 32'(LAT));
            end
        end
        prev_moc = bus.MOC;
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1;
        bus.MOV = 1'b0; bus.RW = 1'b0; bus.Size = 2'd0;
        bus.SignExt = 1'b0; bus.Address = '0; bus.DataIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_dataout", bus.DataOut, 32'd0);
        chk("rst_moc", 32'(bus.MOC), 32'd0);
        chk("rst_alignerr", 32'(bus.AlignErr), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH / 4; i++)
            req(1'b0, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, 1'b0);

        req(1'b0, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, 1'b0);
        req(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0, 1'b0);
        chk("tp_word", bus.DataOut, 32'hDEADBEEF);
        req(1'b1, 2'd0, 1'b0, 32'h010, 32'h0, 0, 1'b0);
        chk("tp_byte_de", bus.DataOut, 32'h0000_00DE);
        req(1'b1, 2'd0, 1'b0, 32'h013, 32'h0, 0, 1'b0);
        chk("tp_byte_ef", bus.DataOut, 32'h0000_00EF);

        req(1'b0, 2'd0, 1'b0, 32'h021, 32'h0000_0080, 0, 1'b0);
        req(1'b1, 2'd0, 1'b1, 32'h021, 32'h0, 0, 1'b0);
        chk("tp_sext_byte", bus.DataOut, 32'hFFFF_FF80);
        req(1'b1, 2'd0, 1'b0, 32'h021, 32'h0, 0, 1'b0);
        chk("tp_zext_byte", bus.DataOut, 32'h0000_0080);
        req(1'b0, 2'd2, 1'b0, 32'h020, 32'h00807F00, 0, 1'b0);
        req(1'b1, 2'd1, 1'b1, 32'h020, 32'h0, 0, 1'b0);
        chk("tp_half", bus.DataOut, 32'h0000_0080);

        req(1'b0, 2'd2, 1'b0, 32'h012, 32'h12345678, 0, 1'b0);
        chk("tp_misalign_dout", bus.DataOut, 32'h0);
        req(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0, 1'b0);
        chk("tp_misalign_ram", bus.DataOut, 32'hDEADBEEF);

        req(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 5, 1'b0);
        req(1'b1, 2'd2, 1'b0, 32'h020, 32'h0, 0, 1'b1);

        req(1'b0, 2'd2, 1'b0, 32'h040, 32'h11223344, 0, 1'b0);
        req(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, 0, 1'b0);
        @(negedge clk);
        bus.MOV = 1'b1; bus.RW = 1'b0; bus.Size = 2'd2;
        bus.Address = 32'h040; bus.DataIn = 32'hA5A5A5A5;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_dataout", bus.DataOut, 32'd0);
        chk("rstmid_moc", 32'(bus.MOC), 32'd0);
        chk("rstmid_busy", 32'(bus.Busy), 32'd0);
        bus.MOV = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_dout = '0;
        req(1'b1, 2'd2, 1'b0, 32'h040, 32'h0, 0, 1'b0);
        chk("tp_rst_ram", bus.DataOut, 32'h11223344);

        req(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'hCAFEF00D, 0, 1'b0);
        req(1'b1, 2'd2, 1'b0, 32'h004, 32'h0, 0, 1'b0);
        chk("tp_wrap", bus.DataOut, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3
                 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            req(1'($urandom), sz, 1'($urandom), a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
